// File: rtl/ra_param_nr1w_if.sv
// Port bundle for ra_param_nr1w: init control, NRD read ports and one write port.
// rd_perr exists only when RA_PARITY_EN is defined.
interface ra_param_nr1w_if #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 64,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                 init_req;
    logic                 init_done;
    logic [NRD-1:0]       rd_enb;
    logic [NRD*AW-1:0]    rd_adr;
    logic [NRD*WIDTH-1:0] rd_dat;
    logic                 wr_enb;
    logic [AW-1:0]        wr_adr;
    logic [WIDTH-1:0]     wr_dat;
`ifdef RA_PARITY_EN
    logic [NRD-1:0]       rd_perr;

    modport master (
        output init_req, rd_enb, rd_adr, wr_enb, wr_adr, wr_dat,
        input  init_done, rd_dat, rd_perr
    );
    modport slave (
        input  init_req, rd_enb, rd_adr, wr_enb, wr_adr, wr_dat,
        output init_done, rd_dat, rd_perr
    );
`else
    modport master (
        output init_req, rd_enb, rd_adr, wr_enb, wr_adr, wr_dat,
        input  init_done, rd_dat
    );
    modport slave (
        input  init_req, rd_enb, rd_adr, wr_enb, wr_adr, wr_dat,
        output init_done, rd_dat
    );
`endif
endinterface

// File: rtl/ra_param_nr1w.sv
// Parametrised NRD-read / 1-write register array: registered inputs, optional read latch,
// optional write bypass and a zero-fill init sequencer. Optional per-entry parity: RA_PARITY_EN.
module ra_param_nr1w #(
    parameter int WIDTH   = 72,
    parameter int DEPTH   = 64,
    parameter int NRD     = 2,
    parameter int LATCHRD = 1,
    parameter int BYPASS  = 1
) (
    input  logic           clk,
    input  logic           reset,
    ra_param_nr1w_if.slave ra
);
    localparam int AW = $clog2(DEPTH);
`ifdef RA_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic                 init_done;

    logic [NRD-1:0]       rd_enb_q, rd_enb_d;
    logic [NRD*AW-1:0]    rd_adr_q, rd_adr_d;
    logic                 wr_enb_q, wr_enb_d;
    logic [AW-1:0]        wr_adr_q, wr_adr_d;
    logic [WIDTH-1:0]     wr_dat_q, wr_dat_d;

    logic [MW-1:0]        mem_q [DEPTH];
    logic                 mem_we;
    logic [AW-1:0]        mem_wa;
    logic [MW-1:0]        mem_wd;
    logic                 wr_ok;

    logic [WIDTH-1:0]     ra_dat [NRD];
    logic [NRD*WIDTH-1:0] rd_dat_flat;
`ifdef RA_PARITY_EN
    logic [NRD-1:0]       ra_perr;
    logic [NRD-1:0]       rd_perr_out;
`endif

    assign init_done    = (state_q == ST_READY);
    assign ra.init_done = init_done;
    assign ra.rd_dat    = rd_dat_flat;
    assign wr_ok        = int'(wr_adr_q) < DEPTH;

    // Requests arriving while the sequencer owns the array are dropped, not queued.
    always_comb begin
        rd_enb_d = init_done ? ra.rd_enb : '0;
        rd_adr_d = ra.rd_adr;
        wr_enb_d = init_done & ra.wr_enb;
        wr_adr_d = ra.wr_adr;
        wr_dat_d = ra.wr_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_enb_q <= '0;
            rd_adr_q <= '0;
            wr_enb_q <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            state_q  <= ST_INIT;
            cnt_q    <= '0;
        end else begin
            rd_enb_q <= rd_enb_d;
            rd_adr_q <= rd_adr_d;
            wr_enb_q <= wr_enb_d;
            wr_adr_q <= wr_adr_d;
            wr_dat_q <= wr_dat_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = wr_adr_q;
`ifdef RA_PARITY_EN
        mem_wd  = {^wr_dat_q, wr_dat_q};
`else
        mem_wd  = wr_dat_q;
`endif
        unique case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                mem_we = wr_enb_q & wr_ok;
                if (ra.init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_comb begin : rd_path
        logic [AW-1:0] adr;
        logic          in_rng;
        logic          hit;
        logic [MW-1:0] word;
        adr    = '0;
        in_rng = 1'b0;
        hit    = 1'b0;
        word   = '0;
`ifdef RA_PARITY_EN
        ra_perr = '0;
`endif
        for (int unsigned p = 0; p < NRD; p++) begin
            adr       = rd_adr_q[p*AW +: AW];
            in_rng    = int'(adr) < DEPTH;
            hit       = (BYPASS != 0) && wr_enb_q && (adr == wr_adr_q);
            word      = in_rng ? mem_q[adr] : '0;
            ra_dat[p] = '0;
            if (rd_enb_q[p] && in_rng) ra_dat[p] = hit ? wr_dat_q : word[WIDTH-1:0];
`ifdef RA_PARITY_EN
            ra_perr[p] = rd_enb_q[p] && in_rng && !hit && (^word);
`endif
        end
    end

    if (LATCHRD != 0) begin : g_latch
        logic [WIDTH-1:0] rd_dat_q [NRD];
        logic [WIDTH-1:0] rd_dat_d [NRD];
`ifdef RA_PARITY_EN
        logic [NRD-1:0]   rd_perr_q, rd_perr_d;
`endif
        // Idle ports hold their last result rather than returning to zero.
        always_comb begin
            for (int unsigned p = 0; p < NRD; p++) begin
                rd_dat_d[p] = rd_enb_q[p] ? ra_dat[p] : rd_dat_q[p];
            end
`ifdef RA_PARITY_EN
            rd_perr_d = (rd_enb_q & ra_perr) | (~rd_enb_q & rd_perr_q);
`endif
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned p = 0; p < NRD; p++) rd_dat_q[p] <= '0;
`ifdef RA_PARITY_EN
                rd_perr_q <= '0;
`endif
            end else begin
                for (int unsigned p = 0; p < NRD; p++) rd_dat_q[p] <= rd_dat_d[p];
`ifdef RA_PARITY_EN
                rd_perr_q <= rd_perr_d;
`endif
            end
        end

        always_comb begin
            rd_dat_flat = '0;
            for (int unsigned p = 0; p < NRD; p++) rd_dat_flat[p*WIDTH +: WIDTH] = rd_dat_q[p];
`ifdef RA_PARITY_EN
            rd_perr_out = rd_perr_q;
`endif
        end
    end else begin : g_nolatch
        always_comb begin
            rd_dat_flat = '0;
            for (int unsigned p = 0; p < NRD; p++) rd_dat_flat[p*WIDTH +: WIDTH] = ra_dat[p];
`ifdef RA_PARITY_EN
            rd_perr_out = ra_perr;
`endif
        end
    end

`ifdef RA_PARITY_EN
    assign ra.rd_perr = rd_perr_out;
`endif
endmodule
